// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, start-bit glitch rejection,
// configurable width/bit order/parity/stop bits, parity and framing error flags.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_data_line,
    output logic                 o_data_ready,
    output logic [DATA_BITS-1:0] o_data_byte_out,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE,
        S_BREAK
    } state_t;

    logic                 sync1_reg;
    logic                 sync2_reg;
    logic                 rx_s;
    state_t               state_reg,    state_next;
    logic [CNT_W-1:0]     cnt_reg,      cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg,  bit_cnt_next;
    logic                 stop_cnt_reg, stop_cnt_next;
    logic [DATA_BITS-1:0] shift_reg,    shift_next;
    logic                 par_bit_reg,  par_bit_next;
    logic                 ferr_reg,     ferr_next;
    logic                 ready_reg,    ready_next;
    logic [DATA_BITS-1:0] data_out_reg, data_out_next;
    logic                 perr_out_reg, perr_out_next;
    logic                 ferr_out_reg, ferr_out_next;

    logic [DATA_BITS-1:0] shifted;
    logic                 xor_all;
    logic                 perr_calc;
    logic                 ferr_now;

    assign rx_s = sync2_reg;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shifted = {shift_reg[DATA_BITS-2:0], rx_s};
        end else begin : g_lsb_first
            assign shifted = {rx_s, shift_reg[DATA_BITS-1:1]};
        end
    endgenerate

    // Parity is judged over the data bits plus the received parity bit.
    assign xor_all   = (^shift_reg) ^ par_bit_reg;
    assign perr_calc = (PARITY_MODE == 1) ? xor_all :
                       (PARITY_MODE == 2) ? ~xor_all : 1'b0;
    assign ferr_now  = ferr_reg | ~rx_s;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            shift_reg    <= '0;
            par_bit_reg  <= 1'b0;
            ferr_reg     <= 1'b0;
            ready_reg    <= 1'b0;
            data_out_reg <= '0;
            perr_out_reg <= 1'b0;
            ferr_out_reg <= 1'b0;
        end else begin
            sync1_reg    <= i_rx_data_line;
            sync2_reg    <= sync1_reg;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            shift_reg    <= shift_next;
            par_bit_reg  <= par_bit_next;
            ferr_reg     <= ferr_next;
            ready_reg    <= ready_next;
            data_out_reg <= data_out_next;
            perr_out_reg <= perr_out_next;
            ferr_out_reg <= ferr_out_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        shift_next    = shift_reg;
        par_bit_next  = par_bit_reg;
        ferr_next     = ferr_reg;
        ready_next    = 1'b0;
        data_out_next = data_out_reg;
        perr_out_next = perr_out_reg;
        ferr_out_next = ferr_out_reg;

        case (state_reg)
            S_IDLE: begin
                cnt_next      = '0;
                bit_cnt_next  = '0;
                stop_cnt_next = 1'b0;
                ferr_next     = 1'b0;
                if (!rx_s) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next   = '0;
                    state_next = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = shifted;
                    if (bit_cnt_reg == BIT_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next     = '0;
                    par_bit_next = rx_s;
                    state_next   = S_STOP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next  = '0;
                    ferr_next = ferr_now;
                    if (stop_cnt_reg == STOP_LAST) begin
                        // Outputs are loaded on entry so they are valid during DONE.
                        state_next    = S_DONE;
                        ready_next    = 1'b1;
                        data_out_next = shift_reg;
                        perr_out_next = perr_calc;
                        ferr_out_next = ferr_now;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_next = ferr_reg ? S_BREAK : S_IDLE;
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign o_data_ready    = ready_reg;
    assign o_data_byte_out = data_out_reg;
    assign o_parity_err    = perr_out_reg;
    assign o_frame_err     = ferr_out_reg;
    assign o_busy          = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three receiver configurations, directed
// scenarios plus randomized frames checked against a frame-level reference model.
module tb_uart_rx_param;

    localparam int CPB  = 10;
    localparam int HALF = CPB / 2;
    localparam int DB_T  [3] = '{8, 8, 7};
    localparam int PM_T  [3] = '{0, 1, 0};
    localparam int SB_T  [3] = '{1, 1, 2};
    localparam int MSB_T [3] = '{1, 0, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       line0, line1, line2;
    logic       rdy0, rdy1, rdy2;
    logic [7:0] dout0, dout1;
    logic [6:0] dout2;
    logic       perr0, perr1, perr2;
    logic       ferr0, ferr1, ferr2;
    logic       busy0, busy1, busy2;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .MSB_FIRST(1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data_line(line0), .o_data_ready(rdy0),
        .o_data_byte_out(dout0), .o_parity_err(perr0), .o_frame_err(ferr0), .o_busy(busy0));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .MSB_FIRST(0)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data_line(line1), .o_data_ready(rdy1),
        .o_data_byte_out(dout1), .o_parity_err(perr1), .o_frame_err(ferr1), .o_busy(busy1));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .MSB_FIRST(1)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data_line(line2), .o_data_ready(rdy2),
        .o_data_byte_out(dout2), .o_parity_err(perr2), .o_frame_err(ferr2), .o_busy(busy2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int word;
        int perr;
        int ferr;
        int due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    task automatic check(input string name, input int d, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, got, expv);
        end
    endtask

    task automatic check_rst(input int d, input int r, input int w, input int p, input int f, input int b);
        check("rst_ready", d, r, 0);
        check("rst_word",  d, w, 0);
        check("rst_perr",  d, p, 0);
        check("rst_ferr",  d, f, 0);
        check("rst_busy",  d, b, 0);
    endtask

    task automatic check_reset_all();
        check_rst(0, int'(rdy0), int'(dout0), int'(perr0), int'(ferr0), int'(busy0));
        check_rst(1, int'(rdy1), int'(dout1), int'(perr1), int'(ferr1), int'(busy1));
        check_rst(2, int'(rdy2), int'(dout2), int'(perr2), int'(ferr2), int'(busy2));
    endtask

    task automatic push_exp(input int d, input exp_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic on_pulse(input int d, input int word, input int pe, input int fe);
        exp_t e;
        int   n;
        n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (n == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse dut%0d: got word %0h at cyc %0d, expected no pulse", d, word, cyc);
            return;
        end
        case (d)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        $display("rx dut%0d cyc=%0d word=%0h perr=%0d ferr=%0d", d, cyc, word, pe, fe);
        check("word",       d, word, e.word);
        check("parity_err", d, pe,   e.perr);
        check("frame_err",  d, fe,   e.ferr);
        check("pulse_cyc",  d, cyc,  e.due);
    endtask

    always @(negedge clk) begin
        if (rdy0) on_pulse(0, int'(dout0), int'(perr0), int'(ferr0));
        if (rdy1) on_pulse(1, int'(dout1), int'(perr1), int'(ferr1));
        if (rdy2) on_pulse(2, int'(dout2), int'(perr2), int'(ferr2));
    end

    task automatic set_line(input int d, input int v);
        case (d)
            0: line0 = (v != 0);
            1: line1 = (v != 0);
            default: line2 = (v != 0);
        endcase
    endtask

    task automatic drive_bit(input int d, input int v);
        set_line(d, v);
        repeat (CPB) @(negedge clk);
    endtask

    // stop_val bit k is the level driven during stop bit k.
    task automatic send_frame(input int d, input int word_in, input bit flip_par, input int stop_val);
        int   db, pm, sb, w, ones, pbit;
        exp_t e;
        db   = DB_T[d];
        pm   = PM_T[d];
        sb   = SB_T[d];
        w    = word_in & ((1 << db) - 1);
        ones = $countones(w);
        pbit = (pm == 2) ? (((ones % 2) == 0) ? 1 : 0) : (ones % 2);
        if (flip_par) pbit = 1 - pbit;
        e.word = w;
        e.perr = (pm == 0) ? 0 :
                 (pm == 1) ? ((ones + pbit) % 2) :
                 ((((ones + pbit) % 2) == 0) ? 1 : 0);
        e.ferr = 0;
        for (int k = 0; k < sb; k++) begin
            if (((stop_val >> k) & 1) == 0) e.ferr = 1;
        end
        e.due = cyc + HALF + (db + ((pm != 0) ? 1 : 0) + sb) * CPB + 3;
        push_exp(d, e);
        $display("tx dut%0d cyc=%0d word=%0h pbit=%0d stops=%0d due=%0d", d, cyc, w, pbit, stop_val, e.due);
        drive_bit(d, 0);
        for (int i = 0; i < db; i++) begin
            drive_bit(d, (MSB_T[d] != 0) ? ((w >> (db - 1 - i)) & 1) : ((w >> i) & 1));
        end
        if (pm != 0) drive_bit(d, pbit);
        for (int k = 0; k < sb; k++) drive_bit(d, (stop_val >> k) & 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        int sv;
        int full;
        rst_n = 1'b0;
        line0 = 1'b1;
        line1 = 1'b1;
        line2 = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_all();
        rst_n = 1'b1;

        // Default format, MSB first.
        repeat (40) @(negedge clk);
        send_frame(0, 'h7A, 1'b0, 1);
        repeat (20) @(negedge clk);
        check("hold_word", 0, int'(dout0), 'h7A);

        // LSB first with even parity: correct then wrong parity bit.
        send_frame(1, 'hA5, 1'b0, 1);
        repeat (10) @(negedge clk);
        send_frame(1, 'hA5, 1'b1, 1);
        repeat (20) @(negedge clk);

        // Three-cycle glitch on an idle line.
        busy_cnt = 0;
        line0 = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 2) line0 = 1'b1;
            if (busy0) busy_cnt++;
        end
        total++;
        if (busy_cnt < 1 || busy_cnt > HALF + 1) begin
            bad++;
            $display("FAIL glitch_busy_cycles dut0: got %0d expected 1..%0d", busy_cnt, HALF + 1);
        end
        check("glitch_busy_end", 0, int'(busy0), 0);

        // Break: low stop bit then line held low, then a clean frame.
        send_frame(0, 'hC3, 1'b0, 0);
        repeat (300) @(negedge clk);
        check("break_busy", 0, int'(busy0), 1);
        line0 = 1'b1;
        repeat (20) @(negedge clk);
        check("break_exit_busy", 0, int'(busy0), 0);
        send_frame(0, 'h3C, 1'b0, 1);
        repeat (20) @(negedge clk);

        // Back-to-back frames, two stop bits, seven data bits.
        send_frame(2, 'h55, 1'b0, 3);
        send_frame(2, 'h2A, 1'b0, 3);
        repeat (20) @(negedge clk);
        check("hold_word", 2, int'(dout2), 'h2A);

        // Reset during data bit 4 aborts the frame.
        drive_bit(0, 0);
        drive_bit(0, 1);
        drive_bit(0, 0);
        drive_bit(0, 0);
        drive_bit(0, 0);
        set_line(0, 0);
        repeat (HALF) @(negedge clk);
        check("midframe_busy", 0, int'(busy0), 1);
        rst_n = 1'b0;
        line0 = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_all();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(0, 'h81, 1'b0, 1);
        repeat (20) @(negedge clk);

        // Randomized frames on every configuration.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 12; n++) begin
                full = (1 << SB_T[d]) - 1;
                sv   = full;
                if ($urandom_range(0, 7) == 0) sv = sv & ~(1 << $urandom_range(0, SB_T[d] - 1));
                send_frame(d, int'($urandom), (PM_T[d] != 0) && ($urandom_range(0, 3) == 0), sv);
                if (sv != full) begin
                    set_line(d, 1);
                    repeat (CPB + 2) @(negedge clk);
                end else begin
                    repeat ($urandom_range(0, 12)) @(negedge clk);
                end
            end
            repeat (20) @(negedge clk);
        end

        for (int i = 0; i < 500 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(negedge clk);
        check("pending_frames", 0, q0.size(), 0);
        check("pending_frames", 1, q1.size(), 0);
        check("pending_frames", 2, q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised successor to the existing fixed-format UART receiver.
- Converts an asynchronous serial line into parallel words with configurable word width, bit order, parity and stop-bit count.
- Adds input synchronisation, start-bit glitch rejection, and parity/framing error reporting.
- Sits between the board RX pin and the command/data consumer logic. Its outputs are compatible with the existing receiver's data_ready/data_byte consumers.

Parameters:
- CLKS_PER_BIT, 10, i_clk cycles per serial bit; must be >= 4.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.
- MSB_FIRST, 1, 1 = first data bit received is the word MSB (current link convention); 0 = LSB first.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_rx_data_line  in  1  raw serial input; idles high.
- o_data_ready  out  1  one-cycle pulse: frame complete, word and error flags valid.
- o_data_byte_out  out  DATA_BITS  received word; held until the next o_data_ready.
- o_parity_err  out  1  parity mismatch on the last frame; valid with and held after o_data_ready.
- o_frame_err  out  1  a stop bit was sampled low on the last frame; valid with and held after o_data_ready.
- o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - Synchroniser flops are set to 1.
  - State goes to IDLE; bit and cycle counters clear.
  - o_data_ready, o_parity_err, o_frame_err and o_busy go to 0; o_data_byte_out goes to 0.
- Reset mid-frame aborts the frame with no o_data_ready. After reset release, the receiver waits for a line-high-to-low transition before accepting a new start bit.
- Input path: a 2-flop synchroniser. All FSM decisions use the second flop (rx_s).
- HALF = CLKS_PER_BIT/2 (integer division).
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE, BREAK.
- IDLE: on rx_s == 0, go to START with the cycle counter cleared.
- START: count to HALF-1 (mid start bit), then sample rx_s.
  - rx_s == 1: glitch; return to IDLE, no outputs change.
  - rx_s == 0: clear counter, go to DATA.
- DATA:
  - Sample rx_s each time the counter reaches CLKS_PER_BIT-1, then clear the counter.
  - Each sample shifts into the data register in the order selected by MSB_FIRST.
  - After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY: one sample after CLKS_PER_BIT cycles.
  - Error when XOR(data bits, parity bit) != 0 for even parity, or == 0 for odd parity.
- STOP: STOP_BITS samples, each after CLKS_PER_BIT cycles. Any stop sample of 0 sets the frame-error condition.
- DONE (one cycle):
  - Pulse o_data_ready.
  - Load o_data_byte_out, o_parity_err and o_frame_err together.
  - If a frame error occurred, go to BREAK; otherwise go to IDLE.
- BREAK: wait for rx_s == 1, then go to IDLE. A held-low line (break) yields exactly one frame with o_frame_err = 1, never a stream of frames.
- Error flags are reported on every o_data_ready. The word is delivered even when an error is flagged.
- Latency: o_data_ready is high in clock cycle HALF + (DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) * CLKS_PER_BIT + 3.
  - Cycle 1 is the first rising i_clk edge that samples i_rx_data_line low.
  - Defaults give cycle 98.
- Back-to-back frames:
  - A start bit that begins on the first cycle after the last stop bit's nominal end is accepted. No idle gap is required beyond STOP_BITS.
  - A falling edge while in DONE is caught in IDLE on the next cycle, with no frame lost.
- o_busy falls in the cycle after DONE (or after BREAK exits).

Test Plan:
- Defaults: idle 40 cycles, send 0x7A MSB-first at 10 clk/bit (start, 8 data, stop) -> one o_data_ready pulse at cycle 98; o_data_byte_out = 0x7A; both error flags 0.
- MSB_FIRST = 0, PARITY_MODE = 1: send 0xA5 LSB-first with parity bit 0 -> 0xA5, o_parity_err = 0. Repeat with parity bit 1 -> 0xA5, o_parity_err = 1.
- Low glitch of 3 cycles on an idle line -> no o_data_ready; o_busy high for at most HALF + 1 cycles, then low.
- Stop bit driven 0 and the line held low for 300 cycles -> exactly one o_data_ready with o_frame_err = 1. After the line returns high, a following frame with 0x3C is received with o_frame_err = 0.
- STOP_BITS = 2, DATA_BITS = 7: two frames 0x55 and 0x2A sent back-to-back with no idle gap -> two pulses exactly 100 cycles apart, words 0x55 and 0x2A, no errors.
- Assert i_rst_n low during data bit 4 of a frame, release, then send 0x81 -> no pulse for the aborted frame; 0x81 received correctly.
